// File: rtl/fpu_writeback_queue.sv
// Writeback FIFO between the FP ALU and the register-file write port.
// It also keeps sticky NaN/Inf/subnormal flags, updated as float-class results retire.
module fpu_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [31:0]       alu_result,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic              alu_is_int,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [31:0]       wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_is_int,
  output logic [CNT_W-1:0]  count,
  output logic [2:0]        flags,
  input  logic              flags_clear
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0]       result;
    logic [ADDR_W-1:0] rd;
    logic              is_int;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       flags_q, flags_d;
  logic             push, pop;
  entry_t           head;
  logic [7:0]       head_exp;
  logic [22:0]      head_man;
  logic [2:0]       new_bits;

  assign alu_ready = (count_q != FULL);
  assign wr_valid  = (count_q != '0);
  assign push      = alu_valid & alu_ready;
  assign pop       = wr_valid & wr_ready;

  always_comb begin
    head = '0;
    if (wr_valid) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign wr_data   = head.result;
  assign wr_addr   = head.rd;
  assign wr_is_int = head.is_int;
  assign count     = count_q;
  assign flags     = flags_q;

  assign head_exp = head.result[30:23];
  assign head_man = head.result[22:0];

  // A pop squashed by flush never retires, so it contributes no flags.
  always_comb begin
    new_bits = 3'b000;
    if (pop && !flush && !head.is_int) begin
      new_bits[2] = (head_exp == 8'hFF) && (head_man != '0);
      new_bits[1] = (head_exp == 8'hFF) && (head_man == '0);
      new_bits[0] = (head_exp == 8'h00) && (head_man != '0);
    end
  end

  always_comb begin
    flags_d  = (flags_clear ? 3'b000 : flags_q) | new_bits;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage has no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{result: alu_result, rd: alu_rd, is_int: alu_is_int};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= 3'b000;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_fpu_writeback_queue.sv
// Scoreboard bench for fpu_writeback_queue: stimulus pushes expected entries,
// a negedge monitor pops and compares on every accepted write.
module tb_fpu_writeback_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        alu_valid;
  logic        alu_ready;
  logic [31:0] alu_result;
  logic [4:0]  alu_rd;
  logic        alu_is_int;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [4:0]  wr_addr;
  logic        wr_is_int;
  logic [2:0]  count;
  logic [2:0]  flags;
  logic        flags_clear;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [37:0] sb [$];

  fpu_writeback_queue #(.DEPTH(4), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_result(alu_result),
    .alu_rd(alu_rd), .alu_is_int(alu_is_int),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_addr(wr_addr), .wr_is_int(wr_is_int),
    .count(count), .flags(flags), .flags_clear(flags_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic set_idle();
    alu_valid = 1'b0; alu_result = '0; alu_rd = '0; alu_is_int = 1'b0;
    wr_ready = 1'b0; flags_clear = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  // One clock of stimulus; alu_ready is checked against the hand-computed value.
  task automatic step(input string name, input logic av, input logic [31:0] d,
                      input logic [4:0] rd, input logic ii, input logic exp_rdy,
                      input logic wrr, input logic fc, input logic fl, input logic rs);
    alu_valid = av; alu_result = d; alu_rd = rd; alu_is_int = ii;
    wr_ready = wrr; flags_clear = fc; flush = fl; reset = rs;
    @(negedge clk);
    check({name, ".alu_ready"}, {31'd0, alu_ready}, {31'd0, exp_rdy});
    if (av && exp_rdy && !fl && !rs) sb.push_back({d, rd, ii});
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic idle_check(input string name, input logic [2:0] exp_cnt,
                            input logic [2:0] exp_flags, input logic exp_wv,
                            input logic exp_rdy);
    @(negedge clk);
    check({name, ".count"}, {29'd0, count}, {29'd0, exp_cnt});
    check({name, ".flags"}, {29'd0, flags}, {29'd0, exp_flags});
    check({name, ".wr_valid"}, {31'd0, wr_valid}, {31'd0, exp_wv});
    check({name, ".alu_ready"}, {31'd0, alu_ready}, {31'd0, exp_rdy});
    if (!exp_wv) begin
      check({name, ".wr_data"}, wr_data, 32'd0);
      check({name, ".wr_addr"}, {27'd0, wr_addr}, 32'd0);
      check({name, ".wr_is_int"}, {31'd0, wr_is_int}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && !flush && wr_valid === 1'b1 && wr_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL mon.unexpected: got %h/%0d/%b expected nothing", wr_data, wr_addr, wr_is_int);
      end else begin
        logic [37:0] e;
        e = sb.pop_front();
        check("mon.write", {wr_data, wr_addr, wr_is_int}, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_check("reset", 3'd0, 3'b000, 1'b0, 1'b1);

    // single pass
    step("t1.push", 1'b1, 32'h3F800000, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_check("t1.held", 3'd1, 3'b000, 1'b1, 1'b1);
    step("t1.pop", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_check("t1.done", 3'd0, 3'b000, 1'b0, 1'b1);

    // fill and stall
    for (int i = 0; i < 4; i++)
      step("fill.push", 1'b1, 32'h4000_0000 + i, 5'(i + 8), 1'(i[0]), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fill.push5", 1'b1, 32'h4000_00FF, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_check("fill.full", 3'd4, 3'b000, 1'b1, 1'b0);
    step("fill.pop_same_cycle", 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_check("fill.after_pop", 3'd3, 3'b000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      step("fill.drain", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_check("fill.empty", 3'd0, 3'b000, 1'b0, 1'b1);

    // simultaneous push/pop at count 2 across pointer wrap
    step("pp.a", 1'b1, 32'hA000_1000, 5'd20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("pp.b", 1'b1, 32'hA000_1001, 5'd21, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step("pp.both", 1'b1, 32'hA000_0000 + i, 5'(i), 1'(i[1]), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_check("pp.count", 3'd2, 3'b000, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++)
      step("pp.drain", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_check("pp.empty", 3'd0, 3'b000, 1'b0, 1'b1);

    // sticky flags
    step("fl.push_nan", 1'b1, 32'h7FC00000, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fl.push_inf", 1'b1, 32'h7F800000, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fl.push_sub", 1'b1, 32'h00000001, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fl.pop_nan", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_check("fl.nv", 3'd2, 3'b100, 1'b1, 1'b1);
    step("fl.pop_inf", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_check("fl.of", 3'd1, 3'b110, 1'b1, 1'b1);
    step("fl.pop_sub", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_check("fl.uf", 3'd0, 3'b111, 1'b0, 1'b1);
    step("fl.clear", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_check("fl.cleared", 3'd0, 3'b000, 1'b0, 1'b1);
    step("fl.push_int_nan", 1'b1, 32'h7FC00000, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fl.pop_int_nan", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_check("fl.int_ignored", 3'd0, 3'b000, 1'b0, 1'b1);
    step("fl.push_inf2", 1'b1, 32'hFF800000, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fl.pop_inf2", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_check("fl.of_only", 3'd0, 3'b010, 1'b0, 1'b1);
    step("fl.push_nan2", 1'b1, 32'h7FC00000, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fl.pop_nan_clear", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_check("fl.clear_and_set", 3'd0, 3'b100, 1'b0, 1'b1);

    // flush with concurrent push
    for (int i = 0; i < 3; i++)
      step("fsh.push", 1'b1, 32'h3F80_0000 + i, 5'(i + 12), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fsh.flush", 1'b1, 32'h7F800000, 5'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    sb.delete();
    idle_check("fsh.after", 3'd0, 3'b100, 1'b0, 1'b1);

    // reset mid-drain
    for (int i = 0; i < 3; i++)
      step("rst.push", 1'b1, 32'h4040_0000 + i, 5'(i + 16), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst.reset", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    sb.delete();
    idle_check("rst.after", 3'd0, 3'b000, 1'b0, 1'b1);

    check("sb.leftover", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
